// File: rtl/ascii_bcd_counter_bank.sv
// rtl/ascii_bcd_counter_bank.sv - bank of prescaled BCD up/down counters presented as ASCII digits
//
// Purpose: N_CH independent decimal counters of N_DIG BCD digits each. A shared
// prescaler produces one count step every PRESCALE clocks while en is high.
// Each channel counts up or down, supports a clamped BCD load, and wraps or
// saturates at its limits according to SAT.
//
// Ports:
//   CLK       system clock, rising edge
//   RSTN      asynchronous active-low reset
//   en        global count enable (gates the prescaler only)
//   dir       per-channel direction, 0 = up, 1 = down
//   load      per-channel synchronous load request (wins over a step)
//   load_val  BCD load values, channel c at [c*N_DIG*4 +: N_DIG*4]
//   ascii     ASCII digits, channel c digit d at [(c*N_DIG+d)*8 +: 8]
//   tick      one-cycle pulse coincident with post-step values
//   ovf       per-channel one-cycle pulse on a limit event
//   upd       one-cycle pulse the cycle after any digit register changed
module ascii_bcd_counter_bank #(
  parameter int N_CH     = 2,
  parameter int N_DIG    = 3,
  parameter int PRESCALE = 10000000,
  parameter int SAT      = 0
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic                      en,
  input  logic [N_CH-1:0]           dir,
  input  logic [N_CH-1:0]           load,
  input  logic [N_CH*N_DIG*4-1:0]   load_val,
  output logic [N_CH*N_DIG*8-1:0]   ascii,
  output logic                      tick,
  output logic [N_CH-1:0]           ovf,
  output logic                      upd
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CW = N_DIG * 4;
  localparam int DW = N_CH * CW;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]   ps_q;
  logic [DW-1:0]   dig_q;
  logic [DW-1:0]   dig_d;
  logic [N_CH-1:0] ovf_d;
  logic            chg_q;
  logic            step;
  logic            carry;
  logic [3:0]      nib;

  assign step = en && (ps_q == PS_LAST);

  // Next digit values per channel: load (clamped) beats step; step ripples a
  // carry/borrow from digit 0 upward. A carry surviving past the top digit
  // means the channel was at its limit.
  always_comb begin
    dig_d = dig_q;
    ovf_d = '0;
    carry = 1'b0;
    nib   = 4'd0;
    for (int c = 0; c < N_CH; c++) begin
      if (load[c]) begin
        for (int d = 0; d < N_DIG; d++) begin
          nib = load_val[(c*N_DIG+d)*4 +: 4];
          dig_d[(c*N_DIG+d)*4 +: 4] = (nib > 4'd9) ? 4'd9 : nib;
        end
      end else if (step) begin
        carry = 1'b1;
        for (int d = 0; d < N_DIG; d++) begin
          nib = dig_q[(c*N_DIG+d)*4 +: 4];
          if (carry) begin
            if (!dir[c]) begin
              if (nib == 4'd9) begin
                dig_d[(c*N_DIG+d)*4 +: 4] = 4'd0;
              end else begin
                dig_d[(c*N_DIG+d)*4 +: 4] = nib + 4'd1;
                carry = 1'b0;
              end
            end else begin
              if (nib == 4'd0) begin
                dig_d[(c*N_DIG+d)*4 +: 4] = 4'd9;
              end else begin
                dig_d[(c*N_DIG+d)*4 +: 4] = nib - 4'd1;
                carry = 1'b0;
              end
            end
          end
        end
        if (carry) begin
          ovf_d[c] = 1'b1;
          // Saturating mode holds the limit value instead of wrapping.
          if (SAT != 0) begin
            dig_d[c*CW +: CW] = dig_q[c*CW +: CW];
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ps_q  <= '0;
      dig_q <= '0;
      tick  <= 1'b0;
      ovf   <= '0;
      chg_q <= 1'b0;
      upd   <= 1'b0;
    end else begin
      if (en) begin
        ps_q <= step ? '0 : ps_q + 1'b1;
      end
      dig_q <= dig_d;
      tick  <= step;
      ovf   <= ovf_d;
      // Change is captured with the new digits, then delayed one more cycle
      // so upd trails the visible value change by one cycle.
      chg_q <= (dig_d != dig_q);
      upd   <= chg_q;
    end
  end

  always_comb begin
    ascii = '0;
    for (int i = 0; i < N_CH*N_DIG; i++) begin
      ascii[i*8 +: 8] = {4'h3, dig_q[i*4 +: 4]};
    end
  end

endmodule

// File: tb/tb_ascii_bcd_counter_bank.sv
// tb/tb_ascii_bcd_counter_bank.sv - self-checking bench for ascii_bcd_counter_bank (wrap and saturate instances)
module tb_ascii_bcd_counter_bank;

  localparam int N_CH     = 2;
  localparam int N_DIG    = 3;
  localparam int PRESCALE = 4;
  localparam int MAXV     = 999;
  localparam int AW       = N_CH * N_DIG * 8;
  localparam int LW       = N_CH * N_DIG * 4;

  logic            CLK;
  logic            RSTN;
  logic            en;
  logic [N_CH-1:0] dir;
  logic [N_CH-1:0] load;
  logic [LW-1:0]   load_val;

  logic [AW-1:0]   a0, a1;
  logic            t0, t1;
  logic [N_CH-1:0] o0, o1;
  logic            p0, p1;

  int n_tests = 0;
  int n_fail  = 0;

  ascii_bcd_counter_bank #(.N_CH(N_CH), .N_DIG(N_DIG), .PRESCALE(PRESCALE), .SAT(0)) u0 (
    .CLK(CLK), .RSTN(RSTN), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .ascii(a0), .tick(t0), .ovf(o0), .upd(p0)
  );

  ascii_bcd_counter_bank #(.N_CH(N_CH), .N_DIG(N_DIG), .PRESCALE(PRESCALE), .SAT(1)) u1 (
    .CLK(CLK), .RSTN(RSTN), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .ascii(a1), .tick(t1), .ovf(o1), .upd(p1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model: each channel is a plain integer 0..999, index [sat][channel].
  int              m_ps;
  int              m_val [2][N_CH];
  bit [N_CH-1:0]   m_ovf [2];
  bit              m_chg [2];
  bit              m_upd [2];
  bit              m_tick;

  function automatic int pow10(input int d);
    int p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  function automatic bit step_now();
    return en && (m_ps == PRESCALE - 1);
  endfunction

  function automatic int load_dec(input int c);
    int v = 0;
    int n;
    for (int d = 0; d < N_DIG; d++) begin
      n = int'(load_val[(c*N_DIG+d)*4 +: 4]);
      if (n > 9) n = 9;
      v = v + n * pow10(d);
    end
    return v;
  endfunction

  function automatic int nxt_val(input int sat, input int c, input int old, input bit st);
    if (load[c]) return load_dec(c);
    if (!st) return old;
    if (!dir[c]) begin
      if (old == MAXV) return (sat != 0) ? MAXV : 0;
      return old + 1;
    end
    if (old == 0) return (sat != 0) ? 0 : MAXV;
    return old - 1;
  endfunction

  function automatic bit nxt_ovf(input int c, input int old, input bit st);
    return !load[c] && st && ((!dir[c] && old == MAXV) || (dir[c] && old == 0));
  endfunction

  function automatic bit any_change(input int sat, input bit st);
    bit r = 1'b0;
    for (int c = 0; c < N_CH; c++)
      if (nxt_val(sat, c, m_val[sat][c], st) != m_val[sat][c]) r = 1'b1;
    return r;
  endfunction

  function automatic logic [AW-1:0] exp_ascii(input int sat);
    logic [AW-1:0] r = '0;
    for (int c = 0; c < N_CH; c++)
      for (int d = 0; d < N_DIG; d++)
        r[(c*N_DIG+d)*8 +: 8] = 8'(48 + (m_val[sat][c] / pow10(d)) % 10);
    return r;
  endfunction

  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      m_ps   <= 0;
      m_tick <= 1'b0;
      for (int s = 0; s < 2; s++) begin
        m_ovf[s] <= '0;
        m_chg[s] <= 1'b0;
        m_upd[s] <= 1'b0;
        for (int c = 0; c < N_CH; c++) m_val[s][c] <= 0;
      end
    end else begin
      if (en) m_ps <= (m_ps == PRESCALE - 1) ? 0 : m_ps + 1;
      m_tick <= step_now();
      for (int s = 0; s < 2; s++) begin
        m_chg[s] <= any_change(s, step_now());
        m_upd[s] <= m_chg[s];
        for (int c = 0; c < N_CH; c++) begin
          m_val[s][c]    <= nxt_val(s, c, m_val[s][c], step_now());
          m_ovf[s][c]    <= nxt_ovf(c, m_val[s][c], step_now());
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Continuous compare of both instances against the model.
  initial begin
    forever begin
      @(negedge CLK);
      check("ascii_wrap", 64'(a0), 64'(exp_ascii(0)));
      check("ascii_sat",  64'(a1), 64'(exp_ascii(1)));
      check("tick_wrap",  64'(t0), 64'(m_tick));
      check("tick_sat",   64'(t1), 64'(m_tick));
      check("ovf_wrap",   64'(o0), 64'(m_ovf[0]));
      check("ovf_sat",    64'(o1), 64'(m_ovf[1]));
      check("upd_wrap",   64'(p0), 64'(m_upd[0]));
      check("upd_sat",    64'(p1), 64'(m_upd[1]));
    end
  end

  initial begin
    RSTN     = 1'b0;
    en       = 1'b0;
    dir      = '0;
    load     = '0;
    load_val = '0;
    repeat (2) @(negedge CLK);
    check("reset_ascii", 64'(a0), 64'h303030_303030);
    RSTN = 1'b1;
    en   = 1'b1;

    // Count up: first tick after PRESCALE edges, carry into tens at 10 ticks.
    repeat (4) @(negedge CLK);
    check("first_tick", 64'(t0), 64'h1);
    check("first_ch0", 64'(a0[23:0]), 64'h303031);
    @(negedge CLK);
    check("upd_after_tick", 64'(p0), 64'h1);
    check("tick_one_cycle", 64'(t0), 64'h0);
    repeat (35) @(negedge CLK);
    check("carry_ch0", 64'(a0[23:0]), 64'h303130);
    check("tick_40", 64'(t0), 64'h1);

    // Asynchronous reset mid-count.
    @(negedge CLK);
    #2 RSTN = 1'b0;
    #1;
    check("async_ascii", 64'(a0), 64'h303030_303030);
    check("async_tick", 64'(t0), 64'h0);
    check("async_ovf",  64'(o0), 64'h0);
    check("async_upd",  64'(p0), 64'h0);

    // Wrap/saturate up: ch0 = 999, ch1 reloaded with its identical value.
    @(negedge CLK);
    RSTN     = 1'b1;
    en       = 1'b0;
    load     = 2'b01;
    load_val = {12'h000, 12'h999};
    @(negedge CLK);
    load = 2'b10;
    en   = 1'b1;
    repeat (4) @(negedge CLK);
    check("wrap_up_ch0", 64'(a0[23:0]), 64'h303030);
    check("wrap_up_ovf", 64'(o0), 64'h1);
    check("sat_up_ch0", 64'(a1[23:0]), 64'h393939);
    check("sat_up_ovf", 64'(o1), 64'h1);
    @(negedge CLK);
    check("wrap_up_upd", 64'(p0), 64'h1);
    check("sat_up_noupd", 64'(p1), 64'h0);
    check("ovf_one_cycle", 64'(o0), 64'h0);

    // Wrap down on ch1 while ch0 counts up.
    load = '0;
    dir  = 2'b10;
    repeat (3) @(negedge CLK);
    check("wrap_dn_ch1", 64'(a0[47:24]), 64'h393939);
    check("wrap_dn_ovf", 64'(o0), 64'h2);
    check("wrap_dn_ch0", 64'(a0[23:0]), 64'h303031);

    // Load with clamp beats a simultaneous step on ch1.
    repeat (3) @(negedge CLK);
    load     = 2'b10;
    load_val = {12'h4C7, 12'h000};
    @(negedge CLK);
    check("load_clamp_ch1", 64'(a0[47:24]), 64'h343937);
    check("load_step_ch0", 64'(a0[23:0]), 64'h303032);
    check("load_tick", 64'(t0), 64'h1);
    load = '0;

    // Freeze prescaler mid-count; resume finishes the remaining count.
    repeat (2) @(negedge CLK);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("gated_tick", 64'(t0), 64'h0);
    end
    check("gated_hold", 64'(a0[23:0]), 64'h303032);
    en = 1'b1;
    @(negedge CLK);
    check("resume_wait", 64'(t0), 64'h0);
    @(negedge CLK);
    check("resume_tick", 64'(t0), 64'h1);
    check("resume_ch0", 64'(a0[23:0]), 64'h303033);
    check("resume_ch1", 64'(a0[47:24]), 64'h343936);

    repeat (3) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
